// File: rtl/soda_credit_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// soda_credit_ctrl_pkg
// Shared definitions for the soda-machine credit/vend controller:
//   - FSM state encodings (2-bit)
//   - coin values in cents
//   - change-coin selection struct
//   - helper to test divisibility of a credit value by 5
// ---------------------------------------------------------------------------
package soda_credit_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_VEND   = 2'b01;
  localparam logic [1:0] ST_CHANGE = 2'b10;

  localparam logic [7:0] VAL_NICKEL  = 8'd5;
  localparam logic [7:0] VAL_DIME    = 8'd10;
  localparam logic [7:0] VAL_QUARTER = 8'd25;

  // One-hot selection of the change coin to eject this cycle.
  typedef struct packed {
    logic q;
    logic d;
    logic n;
  } coin_sel_t;

  // A legal credit is always a whole number of nickels.
  function automatic logic is_mult5(input logic [7:0] v);
    return ((v % 8'd5) == 8'd0);
  endfunction

endpackage

// File: rtl/soda_change_pick.sv
// ---------------------------------------------------------------------------
// soda_change_pick
// Combinational greedy change selector: picks the largest coin
// (quarter, dime, nickel) not exceeding the credit.
// Ports:
//   credit_i [7:0] : credit to pay back, binary cents
//   sel_o          : one-hot {q,d,n} coin to eject (all zero if none fits)
//   sub_o    [7:0] : value of the selected coin, to subtract from credit
//   none_o         : no coin fits (credit below 5)
// ---------------------------------------------------------------------------
module soda_change_pick
  import soda_credit_ctrl_pkg::*;
(
  input  logic [7:0] credit_i,
  output coin_sel_t  sel_o,
  output logic [7:0] sub_o,
  output logic       none_o
);

  // Greedy selection, largest coin first.
  always_comb begin
    sel_o  = '0;
    sub_o  = 8'd0;
    none_o = 1'b0;
    if (credit_i >= VAL_QUARTER) begin
      sel_o.q = 1'b1;
      sub_o   = VAL_QUARTER;
    end else if (credit_i >= VAL_DIME) begin
      sel_o.d = 1'b1;
      sub_o   = VAL_DIME;
    end else if (credit_i >= VAL_NICKEL) begin
      sel_o.n = 1'b1;
      sub_o   = VAL_NICKEL;
    end else begin
      none_o = 1'b1;
    end
  end

endmodule

// File: rtl/soda_credit_ctrl.sv
// ---------------------------------------------------------------------------
// soda_credit_ctrl
// Soda-machine credit/vend controller. Accumulates coin pulses into an
// 8-bit binary credit, vends when the credit covers PRICE, and pays back
// the remainder (or all credit on cancel) one greedy coin per cycle.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   coin_n/d/q        : nickel/dime/quarter inserted (one-cycle pulses)
//   vend_req, cancel  : selection / coin-return request (one-cycle pulses)
//   credit [7:0]      : current credit in cents (feeds the BCD display)
//   vend              : dispense-can pulse
//   coin_reject       : previous cycle's coin input was refused
//   chg_q/d/n         : eject one quarter/dime/nickel of change
//   busy              : machine is vending or paying change
// All outputs are registered; pulses appear the cycle after their cause.
// ---------------------------------------------------------------------------
module soda_credit_ctrl
  import soda_credit_ctrl_pkg::*;
#(
  parameter int unsigned PRICE      = 75,
  parameter int unsigned CREDIT_MAX = 195
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_n,
  input  logic       coin_d,
  input  logic       coin_q,
  input  logic       vend_req,
  input  logic       cancel,
  output logic [7:0] credit,
  output logic       vend,
  output logic       coin_reject,
  output logic       chg_q,
  output logic       chg_d,
  output logic       chg_n,
  output logic       busy
);

  localparam logic [7:0] PRICE_C = 8'(PRICE);
  localparam logic [8:0] CMAX_C  = 9'(CREDIT_MAX);

  logic [1:0] state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic       vend_q, vend_d;
  logic       rej_q, rej_d;
  logic       chg_q_q, chg_q_d;
  logic       chg_d_q, chg_d_d;
  logic       chg_n_q, chg_n_d;
  logic       busy_q, busy_d;

  logic       any_coin_s;
  logic       one_coin_s;
  logic [7:0] coin_val_s;
  logic [8:0] credit_sum_s;
  coin_sel_t  pick_sel_s;
  logic [7:0] pick_sub_s;
  logic       pick_none_s;

  soda_change_pick u_pick (
    .credit_i (credit_q),
    .sel_o    (pick_sel_s),
    .sub_o    (pick_sub_s),
    .none_o   (pick_none_s)
  );

  // Coin decode: value of a single coin, and the 9-bit sum for overflow test.
  always_comb begin
    any_coin_s = coin_n | coin_d | coin_q;
    one_coin_s = 1'b0;
    coin_val_s = 8'd0;
    case ({coin_q, coin_d, coin_n})
      3'b001:  begin one_coin_s = 1'b1; coin_val_s = VAL_NICKEL;  end
      3'b010:  begin one_coin_s = 1'b1; coin_val_s = VAL_DIME;    end
      3'b100:  begin one_coin_s = 1'b1; coin_val_s = VAL_QUARTER; end
      default: begin one_coin_s = 1'b0; coin_val_s = 8'd0;        end
    endcase
    credit_sum_s = {1'b0, credit_q} + {1'b0, coin_val_s};
  end

  // Next-state, next-credit and next-output logic.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    vend_d   = 1'b0;
    rej_d    = 1'b0;
    chg_q_d  = 1'b0;
    chg_d_d  = 1'b0;
    chg_n_d  = 1'b0;
    // busy follows the state one cycle late so it lines up with the pulses.
    busy_d   = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (cancel) begin
          // A coin together with cancel/vend_req is always refused.
          rej_d = any_coin_s;
          if (credit_q != 8'd0) begin
            state_d = ST_CHANGE;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (vend_req) begin
          rej_d = any_coin_s;
          if (credit_q >= PRICE_C) begin
            state_d = ST_VEND;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (any_coin_s) begin
          if (one_coin_s && (credit_sum_s <= CMAX_C)) begin
            credit_d = credit_sum_s[7:0];
          end else begin
            rej_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VEND: begin
        rej_d = any_coin_s;
        if (credit_q >= PRICE_C) begin
          vend_d   = 1'b1;
          credit_d = credit_q - PRICE_C;
          state_d  = (credit_q != PRICE_C) ? ST_CHANGE : ST_IDLE;
        end else begin
          // Cannot happen from IDLE; recover without underflowing.
          credit_d = 8'd0;
          state_d  = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        rej_d = any_coin_s;
        if (!is_mult5(credit_q) || pick_none_s) begin
          // Corrupt credit: drop it rather than pay out a wrong amount.
          credit_d = 8'd0;
          state_d  = ST_IDLE;
        end else begin
          chg_q_d  = pick_sel_s.q;
          chg_d_d  = pick_sel_s.d;
          chg_n_d  = pick_sel_s.n;
          credit_d = credit_q - pick_sub_s;
          state_d  = (credit_q == pick_sub_s) ? ST_IDLE : ST_CHANGE;
        end
      end
      default: begin
        credit_d = 8'd0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State, credit and output pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      credit_q <= 8'd0;
      vend_q   <= 1'b0;
      rej_q    <= 1'b0;
      chg_q_q  <= 1'b0;
      chg_d_q  <= 1'b0;
      chg_n_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      vend_q   <= vend_d;
      rej_q    <= rej_d;
      chg_q_q  <= chg_q_d;
      chg_d_q  <= chg_d_d;
      chg_n_q  <= chg_n_d;
      busy_q   <= busy_d;
    end
  end

  assign credit      = credit_q;
  assign vend        = vend_q;
  assign coin_reject = rej_q;
  assign chg_q       = chg_q_q;
  assign chg_d       = chg_d_q;
  assign chg_n       = chg_n_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_soda_credit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_soda_credit_ctrl
// Scoreboard bench: each stimulus cycle runs a transaction-level model of
// the vending machine and queues the outputs expected after that edge; a
// separate monitor pops and compares them after every rising edge.
// ---------------------------------------------------------------------------
module tb_soda_credit_ctrl;

  localparam int PRICE      = 75;
  localparam int CREDIT_MAX = 195;

  typedef struct packed {
    logic [7:0] credit;
    logic       vend;
    logic       rej;
    logic       cq;
    logic       cd;
    logic       cn;
    logic       busy;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_n = 1'b0, coin_d = 1'b0, coin_q = 1'b0;
  logic       vend_req = 1'b0, cancel = 1'b0;
  logic [7:0] credit;
  logic       vend, coin_reject, chg_q, chg_d, chg_n, busy;

  soda_credit_ctrl #(.PRICE(PRICE), .CREDIT_MAX(CREDIT_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .coin_n      (coin_n),
    .coin_d      (coin_d),
    .coin_q      (coin_q),
    .vend_req    (vend_req),
    .cancel      (cancel),
    .credit      (credit),
    .vend        (vend),
    .coin_reject (coin_reject),
    .chg_q       (chg_q),
    .chg_d       (chg_d),
    .chg_n       (chg_n),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference model state: idle credit plus the outputs still owed for an
  // accepted vend/cancel, one entry per future cycle.
  int   m_credit = 0;
  out_t plan[$];
  out_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Queue the change payout for amount c: quarters, then dimes, then nickels.
  task automatic plan_change(input int c);
    int   nq, nd, nn;
    out_t e;
    nq = c / 25;
    nd = (c % 25) / 10;
    nn = ((c % 25) % 10) / 5;
    for (int i = 0; i < nq + nd + nn; i++) begin
      e = '0;
      e.busy = 1'b1;
      if (i < nq) begin e.cq = 1'b1; c = c - 25; end
      else if (i < nq + nd) begin e.cd = 1'b1; c = c - 10; end
      else begin e.cn = 1'b1; c = c - 5; end
      e.credit = 8'(c);
      plan.push_back(e);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic r, input logic n, input logic d, input logic q,
                      input logic vr, input logic cn);
    out_t e;
    int   val, ncoin;
    logic anyc;
    @(negedge clk);
    rst = r; coin_n = n; coin_d = d; coin_q = q; vend_req = vr; cancel = cn;
    anyc  = n | d | q;
    ncoin = int'(n) + int'(d) + int'(q);
    val   = 5 * int'(n) + 10 * int'(d) + 25 * int'(q);
    e = '0;
    if (r) begin
      m_credit = 0;
      plan.delete();
    end else if (plan.size() > 0) begin
      e = plan.pop_front();
      e.rej = anyc;
    end else if (cn) begin
      e.credit = 8'(m_credit);
      e.rej = anyc;
      if (m_credit > 0) begin
        plan_change(m_credit);
        m_credit = 0;
      end
    end else if (vr) begin
      e.credit = 8'(m_credit);
      e.rej = anyc;
      if (m_credit >= PRICE) begin
        out_t v;
        v = '0;
        v.vend = 1'b1;
        v.busy = 1'b1;
        v.credit = 8'(m_credit - PRICE);
        plan.push_back(v);
        plan_change(m_credit - PRICE);
        m_credit = 0;
      end
    end else begin
      if (anyc) begin
        if (ncoin == 1 && m_credit + val <= CREDIT_MAX) m_credit = m_credit + val;
        else e.rej = 1'b1;
      end
      e.credit = 8'(m_credit);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic coins(input int nq, input int nd, input int nn);
    for (int i = 0; i < nq; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < nd; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nn; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: after every rising edge compare DUT outputs with the scoreboard.
  initial begin
    out_t e, a;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {credit, vend, coin_reject, chg_q, chg_d, chg_n, busy};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs @cycle %0d: got credit=%0d vend=%b rej=%b chg_qdn=%b%b%b busy=%b, want credit=%0d vend=%b rej=%b chg_qdn=%b%b%b busy=%b",
                   cyc, a.credit, a.vend, a.rej, a.cq, a.cd, a.cn, a.busy,
                   e.credit, e.vend, e.rej, e.cq, e.cd, e.cn, e.busy);
        end
      end
    end
  end

  initial begin
    int r;
    // Reset, exact-price vend with no change.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    coins(3, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    // Overpay 85, vend, one dime back.
    coins(3, 1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    // Cancel at 40: quarter, dime, nickel; a coin during change is refused.
    coins(0, 1, 1);
    coins(1, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    // Overflow: 190 + dime refused, then two coins at once refused.
    coins(7, 1, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(12);
    // Insufficient credit, then cancel beats vend_req; coin with vend_req refused.
    coins(2, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(4);
    // Cancel at 195, reset after two quarters.
    coins(7, 2, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)       step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (r < 8)  step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      else if (r < 18) step(1'b0, 1'($urandom_range(0, 9) == 0), 1'b0, 1'b0, 1'b1, 1'b0);
      else if (r < 24) step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      else if (r < 45) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (r < 65) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      else if (r < 85) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      else             step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    idle(2);
    @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
